univ_reg: RTL and testbench



---
 rtl/univ_reg_pkg.sv | 15 +
 rtl/dff_en_srst.sv | 22 ++
 rtl/univ_reg.sv | 60 ++++++
 tb/tb_univ_reg.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/univ_reg_pkg.sv
// Shared mode encoding for the universal register.
package univ_reg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD  = 3'b000;
  localparam mode_t MODE_LOAD  = 3'b001;
  localparam mode_t MODE_SHL   = 3'b010;
  localparam mode_t MODE_SHR   = 3'b011;
  localparam mode_t MODE_ROTL  = 3'b100;
  localparam mode_t MODE_ROTR  = 3'b101;
  localparam mode_t MODE_CNTUP = 3'b110;
  localparam mode_t MODE_CNTDN = 3'b111;

endpackage

// File: rtl/dff_en_srst.sv
// WIDTH-bit D register with synchronous active-low clear to RESET_VAL and enable.
module dff_en_srst #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over enable; with en low the register simply keeps its value.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/univ_reg.sv
// Universal register: hold, load, shift, rotate and up/down count with terminal count.
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             tc
);

  logic [WIDTH-1:0] nxt;

  // Next-state selection by mode; enable and clear are applied in the storage.
  always_comb begin
    nxt = q;
    case (mode)
      MODE_HOLD:  nxt = q;
      MODE_LOAD:  nxt = d;
      MODE_SHL:   nxt = {q[WIDTH-2:0], sin_r};
      MODE_SHR:   nxt = {sin_l, q[WIDTH-1:1]};
      MODE_ROTL:  nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR:  nxt = {q[0], q[WIDTH-1:1]};
      MODE_CNTUP: nxt = q + WIDTH'(1);
      MODE_CNTDN: nxt = q - WIDTH'(1);
      default:    nxt = q;
    endcase
  end

  // Terminal count looks only at q and mode so it is visible even while disabled.
  always_comb begin
    tc = 1'b0;
    if ((mode == MODE_CNTUP) && (q == '1)) tc = 1'b1;
    if ((mode == MODE_CNTDN) && (q == '0)) tc = 1'b1;
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

  dff_en_srst #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_store (
    .clk  (clk),
    .clrn (clrn),
    .en   (en),
    .d    (nxt),
    .q    (q)
  );

endmodule

// File: tb/tb_univ_reg.sv
// Bench for univ_reg: four instances (8/8 with RESET_VAL=55/2/16 bits) against an arithmetic model.
module tb_univ_reg;
  import univ_reg_pkg::*;

  logic        clk = 1'b0;
  logic        clrn;
  logic        en;
  mode_t       mode;
  logic [31:0] d;
  logic        sin_r;
  logic        sin_l;

  logic [7:0]  q8, q8r;
  logic [1:0]  q2;
  logic [15:0] q16;
  logic [3:0]  sla, sra, tca;
  logic [31:0] qa [4];

  int unsigned wid [4] = '{8, 8, 2, 16};
  logic [31:0] rv  [4] = '{32'h0, 32'h55, 32'h0, 32'h0};
  logic [31:0] m   [4];
  bit          v   [4] = '{0, 0, 0, 0};

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  univ_reg #(.WIDTH(8), .RESET_VAL(8'h00)) u8 (
    .clk(clk), .clrn(clrn), .en(en), .mode(mode), .d(d[7:0]), .sin_r(sin_r), .sin_l(sin_l),
    .q(q8), .sout_l(sla[0]), .sout_r(sra[0]), .tc(tca[0]));
  univ_reg #(.WIDTH(8), .RESET_VAL(8'h55)) u8r (
    .clk(clk), .clrn(clrn), .en(en), .mode(mode), .d(d[7:0]), .sin_r(sin_r), .sin_l(sin_l),
    .q(q8r), .sout_l(sla[1]), .sout_r(sra[1]), .tc(tca[1]));
  univ_reg #(.WIDTH(2), .RESET_VAL(2'b00)) u2 (
    .clk(clk), .clrn(clrn), .en(en), .mode(mode), .d(d[1:0]), .sin_r(sin_r), .sin_l(sin_l),
    .q(q2), .sout_l(sla[2]), .sout_r(sra[2]), .tc(tca[2]));
  univ_reg #(.WIDTH(16), .RESET_VAL(16'h0000)) u16 (
    .clk(clk), .clrn(clrn), .en(en), .mode(mode), .d(d[15:0]), .sin_r(sin_r), .sin_l(sin_l),
    .q(q16), .sout_l(sla[3]), .sout_r(sra[3]), .tc(tca[3]));

  assign qa[0] = 32'(q8);
  assign qa[1] = 32'(q8r);
  assign qa[2] = 32'(q2);
  assign qa[3] = 32'(q16);

  function automatic logic [31:0] mask_of(int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  // Model: register value as an integer modulo 2^w.
  function automatic logic [31:0] model_next(logic [31:0] cur, int unsigned w, logic [2:0] md,
                                             logic [31:0] dd, logic sr, logic sl);
    logic [31:0] r;
    case (md)
      3'd0:    r = cur;
      3'd1:    r = dd;
      3'd2:    r = (cur * 2) + 32'(sr);
      3'd3:    r = (cur / 2) + (32'(sl) << (w - 1));
      3'd4:    r = (cur * 2) + (cur >> (w - 1));
      3'd5:    r = (cur / 2) + ((cur % 2) << (w - 1));
      3'd6:    r = cur + 1;
      default: r = cur - 1;
    endcase
    return r & mask_of(w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setin(input logic c, input logic e, input mode_t md, input logic [31:0] dd,
                       input logic sr, input logic sl);
    clrn = c; en = e; mode = md; d = dd; sin_r = sr; sin_l = sl;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic c, input logic e, input mode_t md, input logic [31:0] dd,
                     input logic sr, input logic sl);
    setin(c, e, md, dd, sr, sl);
    edge1();
  endtask

  initial begin
    setin(1'b0, 1'b1, MODE_LOAD, 32'hA5, 1'b0, 1'b0);

    // Reference model update at every rising edge.
    fork
      forever begin
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
          if (!clrn) begin
            m[i] = rv[i];
            v[i] = 1'b1;
          end else if (en && v[i]) begin
            m[i] = model_next(m[i], wid[i], mode, d & mask_of(wid[i]), sin_r, sin_l);
          end
        end
      end
    join_none

    // Every-cycle comparison on the falling edge.
    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          if (v[i]) begin
            chk($sformatf("q[%0d]", i), qa[i], m[i]);
            chk($sformatf("sout_l[%0d]", i), 32'(sla[i]), (m[i] >> (wid[i] - 1)) & 32'h1);
            chk($sformatf("sout_r[%0d]", i), 32'(sra[i]), m[i] & 32'h1);
            chk($sformatf("tc[%0d]", i), 32'(tca[i]),
                32'(((mode == MODE_CNTUP) && (m[i] == mask_of(wid[i]))) ||
                    ((mode == MODE_CNTDN) && (m[i] == 32'h0))));
          end
        end
      end
    join_none

    // Reset dominates enable and LOAD.
    repeat (3) edge1();
    chk("reset_q8", qa[0], 32'h00);
    chk("reset_q8r", qa[1], 32'h55);
    cyc(1'b1, 1'b1, MODE_LOAD, 32'hA5, 1'b0, 1'b0);
    chk("load_a5", qa[0], 32'hA5);
    cyc(1'b1, 1'b0, MODE_LOAD, 32'h3C, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, MODE_LOAD, 32'h3C, 1'b0, 1'b0);
    chk("en_low_hold", qa[0], 32'hA5);

    // Shifts.
    cyc(1'b1, 1'b1, MODE_SHL, 32'h0, 1'b1, 1'b0);
    chk("shl", qa[0], 32'h4B);
    cyc(1'b1, 1'b1, MODE_SHR, 32'h0, 1'b1, 1'b0);
    chk("shr", qa[0], 32'h25);

    // Rotates.
    cyc(1'b1, 1'b1, MODE_LOAD, 32'h81, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, MODE_ROTL, 32'h0, 1'b0, 1'b0);
    chk("rotl", qa[0], 32'h03);
    cyc(1'b1, 1'b1, MODE_LOAD, 32'h81, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, MODE_ROTR, 32'h0, 1'b0, 1'b0);
    chk("rotr1", qa[0], 32'hC0);
    cyc(1'b1, 1'b1, MODE_ROTR, 32'h0, 1'b0, 1'b0);
    chk("rotr2", qa[0], 32'h60);
    cyc(1'b1, 1'b1, MODE_LOAD, 32'h81, 1'b0, 1'b0);
    repeat (8) cyc(1'b1, 1'b1, MODE_ROTL, 32'h0, 1'b0, 1'b0);
    chk("rotl8", qa[0], 32'h81);

    // Up-count wrap with terminal count.
    cyc(1'b1, 1'b1, MODE_LOAD, 32'hFE, 1'b0, 1'b0);
    setin(1'b1, 1'b1, MODE_CNTUP, 32'h0, 1'b0, 1'b0);
    #1 chk("tc_at_fe", 32'(tca[0]), 32'h0);
    edge1();
    chk("cnt_ff", qa[0], 32'hFF);
    chk("tc_at_ff", 32'(tca[0]), 32'h1);
    edge1();
    chk("cnt_wrap", qa[0], 32'h00);
    chk("tc_at_00", 32'(tca[0]), 32'h0);

    // Down-count wrap.
    cyc(1'b1, 1'b1, MODE_LOAD, 32'h01, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, MODE_CNTDN, 32'h0, 1'b0, 1'b0);
    chk("dn_00", qa[0], 32'h00);
    chk("tc_dn_00", 32'(tca[0]), 32'h1);
    edge1();
    chk("dn_wrap", qa[0], 32'hFF);

    // Reset mid-count.
    cyc(1'b1, 1'b1, MODE_LOAD, 32'h10, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, MODE_CNTUP, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, MODE_CNTUP, 32'h0, 1'b0, 1'b0);
    chk("cnt_12", qa[0], 32'h12);
    cyc(1'b0, 1'b1, MODE_CNTUP, 32'h0, 1'b0, 1'b0);
    chk("midreset_q8", qa[0], 32'h00);
    chk("midreset_q8r", qa[1], 32'h55);

    // tc while disabled.
    cyc(1'b1, 1'b1, MODE_LOAD, 32'hFF, 1'b0, 1'b0);
    setin(1'b1, 1'b0, MODE_CNTUP, 32'h0, 1'b0, 1'b0);
    #1 chk("tc_disabled", 32'(tca[0]), 32'h1);
    edge1();
    chk("hold_disabled", qa[0], 32'hFF);
    chk("tc_disabled2", 32'(tca[0]), 32'h1);

    // Width sweep: 2 and 16 bits.
    cyc(1'b1, 1'b1, MODE_LOAD, 32'h0000FFFF, 1'b0, 1'b0);
    chk("w2_load", qa[2], 32'h3);
    chk("w16_load", qa[3], 32'hFFFF);
    cyc(1'b1, 1'b1, MODE_CNTUP, 32'h0, 1'b0, 1'b0);
    chk("w2_wrap", qa[2], 32'h0);
    chk("w16_wrap", qa[3], 32'h0);
    cyc(1'b1, 1'b1, MODE_LOAD, 32'h00008002, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, MODE_SHL, 32'h0, 1'b1, 1'b0);
    chk("w2_shl", qa[2], 32'h1);
    chk("w16_shl", qa[3], 32'h0005);

    // Random traffic checked by the model every cycle.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(31) != 0) ? 1'b1 : 1'b0,
          ($urandom_range(7) != 0) ? 1'b1 : 1'b0,
          mode_t'($urandom_range(7)), $urandom(),
          1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
